dmem_ctrl: RTL and testbench

Data-memory controller sitting directly downstream of the CPU's memory stage. It accepts one word load/store per instruction from the core, services it from a synchronous single-port block RAM (one-cycle read latency) or from a small memory-mapped I/O window, and raises `stall` so the single-cycle core holds its PC and request while a RAM load completes. Stores and MMIO accesses complete without stalling.

---
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the core's memory stage.
//   Services one word load/store per instruction from a synchronous
//   single-port BRAM (1-cycle read latency) or a 16-byte MMIO window.
//   RAM loads stall the core for two cycles; all other accesses finish
//   in one cycle.
// Ports:
//   sys_clk, rst        clock, async active-high reset
//   req_read/req_write  load/store request (held by core while stall=1)
//   req_addr, req_wdata byte address, store data
//   rdata_o             load data, valid in the cycle stall=0
//   stall               combinational core freeze
//   addr_err            one-cycle registered pulse on an illegal access
//   bram_*              BRAM port (word address, write data, read data)
//   led_o, sw_i         LED register output, asynchronous switch inputs
module dmem_ctrl #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic [31:0]           rdata_o,
    output logic                  stall,
    output logic                  addr_err,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    input  logic [31:0]           bram_rdata,
    output logic [15:0]           led_o,
    input  logic [15:0]           sw_i
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    typedef struct packed {
        logic ram;
        logic mmio;
        logic aligned;
    } dec_t;

    state_t      state, state_nxt;
    dec_t        dec;
    logic [31:0] rdata_q;
    logic [31:0] scratch;
    logic [31:0] cycle_cnt;
    logic [15:0] led;
    logic [15:0] sw_meta, sw_sync;
    logic [31:0] mmio_rdata;

    logic dec_en, illegal, legal;
    logic ram_rd, ram_wr, mmio_rd, mmio_wr;

    assign bram_addr  = req_addr[ADDR_WIDTH+1:2];
    assign bram_wdata = req_wdata;
    assign led_o      = led;

    // Address decode
    always_comb begin
        dec.ram     = (req_addr[31:ADDR_WIDTH+2] == '0);
        dec.mmio    = (req_addr[31:4] == MMIO_BASE[31:4]);
        dec.aligned = (req_addr[1:0] == 2'b00);
    end

    // Requests are only decoded in IDLE: in RD_WAIT/RD_DONE the bus still
    // carries the load being serviced. Gating with rst makes stall, bram_en
    // and rdata_o fall immediately when reset hits with a request present.
    always_comb begin
        dec_en  = (state == IDLE) && !rst && (req_read || req_write);
        illegal = dec_en && (!dec.aligned || !(dec.ram || dec.mmio) ||
                             (req_read && req_write));
        legal   = dec_en && !illegal;
        ram_rd  = legal && req_read  && dec.ram;
        ram_wr  = legal && req_write && dec.ram;
        mmio_rd = legal && req_read  && dec.mmio;
        mmio_wr = legal && req_write && dec.mmio;
    end

    always_comb begin
        case (req_addr[3:2])
            2'd0:    mmio_rdata = {16'b0, led};
            2'd1:    mmio_rdata = {16'b0, sw_sync};
            2'd2:    mmio_rdata = cycle_cnt;
            default: mmio_rdata = scratch;
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state and outputs
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        bram_en   = ram_rd || ram_wr;
        bram_we   = ram_wr;
        rdata_o   = '0;
        case (state)
            IDLE: begin
                if (ram_rd) begin
                    stall     = 1'b1;
                    state_nxt = RD_WAIT;
                end else if (mmio_rd) begin
                    rdata_o = mmio_rdata;
                end
            end
            RD_WAIT: begin
                stall     = 1'b1;
                state_nxt = RD_DONE;
            end
            RD_DONE: begin
                rdata_o   = rdata_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rdata_q   <= '0;
            scratch   <= '0;
            cycle_cnt <= '0;
            led       <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            addr_err  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            sw_meta   <= sw_i;
            sw_sync   <= sw_meta;
            addr_err  <= illegal;
            if (state == RD_WAIT) rdata_q <= bram_rdata;
            // Writes to read-only offsets (+4, +8) fall through silently.
            if (mmio_wr) begin
                case (req_addr[3:2])
                    2'd0:    led     <= req_wdata[15:0];
                    2'd3:    scratch <= req_wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    localparam int AW = 14;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic          sys_clk, rst;
    logic          req_read, req_write;
    logic [31:0]   req_addr, req_wdata;
    logic [31:0]   rdata_o;
    logic          stall, addr_err, bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata, bram_rdata;
    logic [15:0]   led_o, sw_i;

    dmem_ctrl #(.ADDR_WIDTH(AW), .MMIO_BASE(MB)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata_o(rdata_o), .stall(stall), .addr_err(addr_err),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .led_o(led_o), .sw_i(sw_i)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous single-port BRAM, one-cycle read latency
    logic [31:0] mem [0:(1<<AW)-1];
    initial bram_rdata = '0;
    always @(posedge sys_clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            bram_rdata <= mem[bram_addr];
        end
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   ref_mem [int];
    logic [31:0]   exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_read = rd; req_write = wr; req_addr = a; req_wdata = d;
    endtask

    task automatic idle_cyc();
        @(negedge sys_clk); drive(0, 0, 32'h0, 32'h0); #1;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input string tag);
        @(negedge sys_clk); drive(0, 1, a, d); #1;
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        if (a < (32'd4 << AW)) begin
            chk({tag, "_we"},    32'(bram_we), 32'd1);
            chk({tag, "_waddr"}, 32'(bram_addr), a >> 2);
            chk({tag, "_wdata"}, bram_wdata, d);
            ref_mem[int'(a >> 2)] = d;
        end else begin
            chk({tag, "_en"}, 32'(bram_en), 32'd0);
        end
    endtask

    // Push the expected result at issue, pop it when the DUT releases stall.
    task automatic do_rd(input logic [31:0] a, input logic [31:0] exp, input int exp_stalls, input string tag);
        int   stalls;
        logic done;
        exp_q.push_back(exp);
        @(negedge sys_clk); drive(1, 0, a, 32'h0); #1;
        if (a < (32'd4 << AW)) begin
            chk({tag, "_en"},   32'(bram_en), 32'd1);
            chk({tag, "_addr"}, 32'(bram_addr), a >> 2);
        end
        stalls = 0; done = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            if (stall) begin
                stalls++;
                @(negedge sys_clk); #1;
            end else begin
                done = 1;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stalls"}, stalls, exp_stalls);
        if (done) chk({tag, "_data"}, rdata_o, exp_q.pop_front());
        else void'(exp_q.pop_front());
    endtask

    task automatic do_bad(input logic rd, input logic wr, input logic [31:0] a, input string tag);
        @(negedge sys_clk); drive(rd, wr, a, 32'h5555_AAAA); #1;
        chk({tag, "_en"},    32'(bram_en), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_rdata"}, rdata_o, 32'd0);
        idle_cyc();
        chk({tag, "_err1"}, 32'(addr_err), 32'd1);
        idle_cyc();
        chk({tag, "_err0"}, 32'(addr_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] v1, v2;

    initial begin
        rst = 1'b1; sw_i = '0;
        drive(0, 0, 32'h0, 32'h0);
        repeat (2) @(negedge sys_clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_en",    32'(bram_en), 32'd0);
        chk("rst_we",    32'(bram_we), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err",   32'(addr_err), 32'd0);
        chk("rst_led",   32'(led_o), 32'd0);
        @(negedge sys_clk); rst = 1'b0;

        // Store then load
        do_wr(32'h40, 32'hDEAD_BEEF, "st40");
        do_rd(32'h40, ref_mem[32'h10], 2, "ld40");

        // Back-to-back loads
        do_wr(32'h0, 32'h11, "st0");
        do_wr(32'h4, 32'h22, "st4");
        do_rd(32'h0, ref_mem[0], 2, "b2b0");
        do_rd(32'h4, ref_mem[1], 2, "b2b1");

        // MMIO LED / scratch / read-only write
        do_wr(MB, 32'h1234_ABCD, "led_wr");
        idle_cyc();
        chk("led_o", 32'(led_o), 32'h0000_ABCD);
        do_rd(MB, 32'h0000_ABCD, 0, "led_rd");
        do_wr(MB + 32'hC, 32'hCAFE_F00D, "scr_wr");
        do_rd(MB + 32'hC, 32'hCAFE_F00D, 0, "scr_rd");
        do_wr(MB + 32'h4, 32'hFFFF_FFFF, "sw_wr");
        idle_cyc();
        chk("sw_wr_err", 32'(addr_err), 32'd0);
        do_rd(MB + 32'h4, 32'h0, 0, "sw_ro");

        // Switch synchronizer latency
        @(negedge sys_clk); sw_i = 16'h00F0; drive(1, 0, MB + 32'h4, 32'h0); #1;
        chk("sw_c0", rdata_o, 32'h0);
        @(negedge sys_clk); #1;
        chk("sw_c1", rdata_o, 32'h0);
        @(negedge sys_clk); #1;
        chk("sw_c2", rdata_o, 32'h0000_00F0);

        // Cycle counter difference
        @(negedge sys_clk); drive(1, 0, MB + 32'h8, 32'h0); #1;
        v1 = rdata_o;
        chk("cnt_stall", 32'(stall), 32'd0);
        repeat (5) @(negedge sys_clk);
        #1;
        v2 = rdata_o;
        chk("cnt_diff", v2 - v1, 32'd5);

        // Illegal accesses; memory must be untouched
        do_bad(1, 0, 32'h41, "mis_ld");
        do_bad(0, 1, 32'h42, "mis_st");
        do_bad(0, 1, 32'h8000_0000, "unmap");
        do_bad(1, 1, 32'h40, "rdwr");
        do_rd(32'h40, ref_mem[32'h10], 2, "ld40b");

        // Reset during RD_WAIT
        @(negedge sys_clk); drive(1, 0, 32'h4, 32'h0); #1;
        chk("rw_c0_stall", 32'(stall), 32'd1);
        @(negedge sys_clk); #1;
        chk("rw_c1_stall", 32'(stall), 32'd1);
        rst = 1'b1; #1;
        chk("rw_rst_stall", 32'(stall), 32'd0);
        chk("rw_rst_en",    32'(bram_en), 32'd0);
        chk("rw_rst_rdata", rdata_o, 32'd0);
        chk("rw_rst_led",   32'(led_o), 32'd0);
        @(negedge sys_clk); rst = 1'b0; drive(0, 0, 32'h0, 32'h0); #1;
        chk("rw_idle_stall", 32'(stall), 32'd0);
        do_rd(32'h4, ref_mem[1], 2, "rw_ld");

        // Counter wrap
        @(negedge sys_clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        drive(1, 0, MB + 32'h8, 32'h0); #1;
        chk("wrap0", rdata_o, 32'hFFFF_FFFF);
        release dut.cycle_cnt;
        @(negedge sys_clk); #1;
        chk("wrap1", rdata_o, 32'h0);

        idle_cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
